// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for the 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             ResultSrcE,
    input  logic             RegWriteE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StWait = 1'b1;
    localparam logic [WAIT_W-1:0] WaitMax = WAIT_MAX[WAIT_W-1:0];

    logic              freeze;
    logic              loaduse;
    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign freeze  = MemReqM & ~MemReadyM;
    assign loaduse = ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                     ((RD_E == RS1_D) | (RD_E == RS2_D));

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(RS1_E, RD_M, RegWriteM, RD_W, RegWriteW);
            ForwardBE = fwd_sel(RS2_E, RD_M, RegWriteM, RD_W, RegWriteW);
            // Freeze holds E, so a pending branch or load-use re-evaluates afterwards.
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loaduse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d    = StWait;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            StWait: begin
                if (MemReadyM) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WaitMax) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = StRun;
        endcase
        // Raise on the edge that ends wait cycle WAIT_MAX; the access itself keeps waiting.
        if ((state_d == StWait) && (wait_cnt_d == WaitMax)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (FlushE && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCycles = flush_cnt_q;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It watches the register indices and control bits leaving decode, execute, memory and writeback. From them it drives the stall, flush and forwarding controls of the fetch, decode/execute, execute/memory and memory/writeback pipeline registers. It also owns the data-memory wait handshake: a small FSM freezes the pipeline while a load/store in the memory stage waits on memory, and flags a stuck access.

## Interface
Parameters:
- WAIT_MAX, 255: wait-cycle limit for a memory access before MemTimeout sets; 1..2^WAIT_W-1.
- WAIT_W, 8: width of the internal wait counter.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- RS1_D, RS2_D  in  5  source register indices of the instruction in decode.
- RS1_E, RS2_E, RD_E  in  5  source and destination indices in execute.
- ResultSrcE  in  1  execute instruction is a load.
- RegWriteE  in  1  execute instruction writes the register file.
- PCSrcE  in  1  branch taken, resolved in execute.
- RD_M, RegWriteM  in  5/1  destination index and write enable in memory.
- RD_W, RegWriteW  in  5/1  destination index and write enable in writeback.
- MemReqM  in  1  memory-stage instruction is a load/store.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALU result from memory stage.
- StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register.
- FlushD, FlushE, FlushW  out  1  load a bubble (all control bits 0) into IF-ID / ID-EX / MEM-WB.
- MemTimeout  out  1  sticky; a memory access exceeded WAIT_MAX wait cycles.
- StallCycles, FlushCycles  out  CNT_W  performance counters.

## Operation
Forwarding is combinational, evaluated separately for A (RS1_E) and B (RS2_E):
- Select 10 if RegWriteM, RD_M≠0 and RD_M equals the source.
- Otherwise select 01 if RegWriteW, RD_W≠0 and RD_W equals the source.
- Otherwise select 00. The memory stage wins when both match.

Hazard conditions:
- freeze = MemReqM & ~MemReadyM.
- loaduse = ResultSrcE & RegWriteE & RD_E≠0 & (RD_E==RS1_D | RD_E==RS2_D).

Outputs follow a fixed priority, freeze > PCSrcE > loaduse:
- freeze: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD and FlushE stay 0. A pending PCSrcE or loaduse is deferred; because E is held, it re-evaluates once freeze drops.
- PCSrcE (no freeze): FlushD=FlushE=1 and no stalls. This overrides a simultaneous loaduse.
- loaduse only: StallF=StallD=1 and FlushE=1.
- none: all stall and flush outputs are 0.

Memory-wait FSM, states RUN and WAIT:
- RUN→WAIT when freeze; WaitCnt←1.
- In WAIT with MemReadyM=0: WaitCnt increments and saturates at WAIT_MAX. When WaitCnt==WAIT_MAX, MemTimeout←1.
- A timeout does not abort the access; the pipeline stays frozen until MemReadyM.
- WAIT→RUN when MemReadyM=1; WaitCnt←0.
- In RUN, MemReqM & MemReadyM in the same cycle completes the access with no stall and no state change.

## Timing
- Every stall, flush and forward output is combinational from the current inputs. Zero-cycle latency, so the pipeline registers see them at the same edge.
- While rst=1, all stall/flush outputs are forced to 0 and ForwardAE/BE to 00.
- At the first edge with rst=1: state←RUN, WaitCnt←0, MemTimeout←0, and both counters←0.
- Reset mid-WAIT returns to RUN in one edge. Stall outputs drop immediately unless freeze is still true after reset releases.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- A memory wait of N cycles with MemReadyM=0 costs N stall cycles. MemTimeout rises at the edge ending wait cycle WAIT_MAX.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCycles increments on every edge where StallF=1.
  - FlushCycles increments on every edge where FlushE=1.
  - Both saturate at 2^CNT_W-1 and clear on rst.
- Undefined: no counter flops are built. StallCycles and FlushCycles are tied to 0, and the ports remain.

## Test plan
- Forwarding: RS1_E=5, RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Repeat with RD_M=RD_W=0 → 00.
- Load-use: RD_E=3, ResultSrcE=RegWriteE=1, RS2_D=3 → StallF=StallD=FlushE=1 for exactly one cycle. With RD_E=0 → no stall.
- Branch + load-use in the same cycle: PCSrcE=1 with the loaduse condition → FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 → StallF..StallM=1 and FlushW=1 for 4 cycles. FSM back in RUN. MemTimeout stays 0.
- Timeout: WAIT_MAX=3, MemReadyM held 0 for 6 cycles → MemTimeout=1 after the 3rd wait cycle, pipeline still frozen. MemTimeout holds after MemReadyM and clears only on rst.
- Perf (HAZARD_PERF_CNT_EN, CNT_W=4): 20 stall cycles → StallCycles=15 saturated. rst → 0. Macro undefined → both counters read 0.
